// File: rtl/instr_mem_loader_if.sv
// Fetch and program-load signal bundle for instr_mem_loader.
// master: CPU fetch stage plus host/UART loader. slave: the instruction memory.
interface instr_mem_loader_if #(
    parameter int DATA_W = 28,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] iAddress;
    logic              iFetchEn;
    logic [DATA_W-1:0] oInstruction;
    logic              oInstrValid;
    logic              iLoadStart;
    logic [ADDR_W-1:0] iLoadBase;
    logic [ADDR_W:0]   iLoadCount;
    logic [DATA_W-1:0] iLoadData;
    logic              iLoadValid;
    logic              oLoadReady;
    logic              oLoadBusy;
    logic              oLoadDone;

    modport master (
        output iAddress, iFetchEn, iLoadStart, iLoadBase, iLoadCount,
               iLoadData, iLoadValid,
        input  oInstruction, oInstrValid, oLoadReady, oLoadBusy, oLoadDone
    );

    modport slave (
        input  iAddress, iFetchEn, iLoadStart, iLoadBase, iLoadCount,
               iLoadData, iLoadValid,
        output oInstruction, oInstrValid, oLoadReady, oLoadBusy, oLoadDone
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with registered fetch and a run-time valid/ready program
// load port. Words never written since reset read back as NOP_WORD.
module instr_mem_loader #(
    parameter int                DATA_W   = 28,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input logic                Clock,
    input logic                Reset,
    instr_mem_loader_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;
    logic [DEPTH-1:0]  written;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] instr_q;
    logic              instr_valid_q;
    logic              wr_en;

    // Ready/busy/done are pure decodes of the state register, so they carry
    // no combinational path from any input.
    assign bus.oLoadReady   = (state == LOAD);
    assign bus.oLoadBusy    = (state != IDLE);
    assign bus.oLoadDone    = (state == DONE);
    assign bus.oInstruction = instr_q;
    assign bus.oInstrValid  = instr_valid_q;

    assign wr_en = (state == LOAD) && bus.iLoadValid && !Reset;

    // Load session FSM: pointer, remaining count and per-word written bits.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            ptr     <= '0;
            rem     <= '0;
            written <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iLoadStart) begin
                        ptr   <= bus.iLoadBase;
                        rem   <= bus.iLoadCount;
                        state <= (bus.iLoadCount != '0) ? LOAD : DONE;
                    end
                end
                LOAD: begin
                    if (bus.iLoadValid) begin
                        written[ptr] <= 1'b1;
                        ptr          <= ptr + ADDR_W'(1);
                        rem          <= rem - (ADDR_W+1)'(1);
                        if (rem == (ADDR_W+1)'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Storage array has no reset so it can map onto block RAM; validity of
    // its contents is tracked separately by the written bits.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[ptr] <= bus.iLoadData;
        end
    end

    // Registered fetch port, served only while no load session is active.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
        end else if (bus.iFetchEn) begin
            if (state == IDLE) begin
                instr_q       <= written[bus.iAddress] ? mem[bus.iAddress] : NOP_WORD;
                instr_valid_q <= 1'b1;
            end else begin
                instr_q       <= NOP_WORD;
                instr_valid_q <= 1'b0;
            end
        end else begin
            instr_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: scoreboard of expected fetch words
// built from a reference memory model, plus inline load-handshake checks.
module tb_instr_mem_loader;
    localparam int                DATA_W = 28;
    localparam int                ADDR_W = 8;
    localparam logic [DATA_W-1:0] NOP    = 28'h0F0000F;

    logic clk = 1'b0;
    logic rst;

    instr_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    instr_mem_loader #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NOP_WORD(NOP)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem_m [256];
    bit                wr_m  [256];
    logic [DATA_W-1:0] exp_q [$];

    // {ready, busy, done}
    logic [2:0] st;
    assign st = {bus.oLoadReady, bus.oLoadBusy, bus.oLoadDone};

    function automatic logic [DATA_W-1:0] model_rd(input logic [7:0] a);
        return wr_m[a] ? mem_m[a] : NOP;
    endfunction

    task automatic model_clear();
        foreach (wr_m[i]) wr_m[i] = 1'b0;
    endtask

    task automatic model_wr(input logic [7:0] a, input logic [DATA_W-1:0] d);
        mem_m[a] = d;
        wr_m[a]  = 1'b1;
    endtask

    task automatic drive_fetch(input logic [7:0] a);
        bus.iFetchEn = 1'b1;
        bus.iAddress = a;
        exp_q.push_back(model_rd(a));
    endtask

    task automatic start_load(input logic [7:0] base, input logic [8:0] cnt);
        bus.iLoadStart = 1'b1;
        bus.iLoadBase  = base;
        bus.iLoadCount = cnt;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] e;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.oInstruction !== NOP) begin
            errors++; $display("FAIL reset_instr: got %h want %h", bus.oInstruction, NOP);
        end
        checks++;
        if (bus.oInstrValid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.oInstrValid);
        end
        checks++;
        if (st !== 3'b000) begin
            errors++; $display("FAIL reset_status: got %b want 000", st);
        end
        rst = 1'b0;
        model_clear();
        // fetch 0..3 back to back from an empty memory
        for (int unsigned i = 0; i < 4; i++) begin
            drive_fetch(8'(i));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== e) begin
                errors++; $display("FAIL unwritten_fetch[%0d]: got %b/%h want 1/%h", i, bus.oInstrValid, bus.oInstruction, e);
            end
        end
        bus.iFetchEn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.oInstrValid !== 1'b0) begin
            errors++; $display("FAIL fetch_off_valid: got %b want 0", bus.oInstrValid);
        end
    endtask

    task automatic test_load_basic();
        logic [DATA_W-1:0] d [3] = '{28'h0A00001, 28'h0B00002, 28'h0C00003};
        logic [7:0]        a [3] = '{8'h00, 8'h01, 8'h02};
        logic [DATA_W-1:0] e;
        start_load(8'h00, 9'd3);
        @(negedge clk);
        bus.iLoadStart = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            checks++;
            if (st !== 3'b110) begin
                errors++; $display("FAIL basic_ready[%0d]: got %b want 110", i, st);
            end
            bus.iLoadValid = 1'b1;
            bus.iLoadData  = d[i];
            model_wr(8'(i), d[i]);
            @(negedge clk);
        end
        bus.iLoadValid = 1'b0;
        checks++;
        if (st !== 3'b011) begin
            errors++; $display("FAIL basic_done: got %b want 011", st);
        end
        @(negedge clk);
        checks++;
        if (st !== 3'b000) begin
            errors++; $display("FAIL basic_idle: got %b want 000", st);
        end
        foreach (a[i]) begin
            drive_fetch(a[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== e) begin
                errors++; $display("FAIL basic_fetch[%0d]: got %b/%h want 1/%h", i, bus.oInstrValid, bus.oInstruction, e);
            end
        end
        bus.iFetchEn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.oInstrValid !== 1'b0 || bus.oInstruction !== d[2]) begin
            errors++; $display("FAIL basic_hold: got %b/%h want 0/%h", bus.oInstrValid, bus.oInstruction, d[2]);
        end
    endtask

    task automatic test_load_stall_wrap();
        logic [7:0]        p = 8'hFE;
        logic [7:0]        a [6] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        logic [DATA_W-1:0] e;
        start_load(8'hFE, 9'd4);
        @(negedge clk);
        bus.iLoadStart = 1'b0;
        for (int unsigned c = 0; c < 7; c++) begin
            checks++;
            if (st !== 3'b110) begin
                errors++; $display("FAIL wrap_ready[%0d]: got %b want 110", c, st);
            end
            if (c % 2 == 0) begin
                bus.iLoadValid = 1'b1;
                bus.iLoadData  = 28'h1230000 | DATA_W'(c);
                model_wr(p, 28'h1230000 | DATA_W'(c));
                p++;
            end else begin
                bus.iLoadValid = 1'b0;
                bus.iLoadData  = 28'hBADBAD0 | DATA_W'(c);
            end
            @(negedge clk);
        end
        bus.iLoadValid = 1'b0;
        checks++;
        if (st !== 3'b011) begin
            errors++; $display("FAIL wrap_done: got %b want 011", st);
        end
        @(negedge clk);
        foreach (a[i]) begin
            drive_fetch(a[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== e) begin
                errors++; $display("FAIL wrap_fetch[%h]: got %b/%h want 1/%h", a[i], bus.oInstrValid, bus.oInstruction, e);
            end
        end
        bus.iFetchEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_zero();
        logic [7:0]        a [3] = '{8'h30, 8'h00, 8'hFF};
        logic [DATA_W-1:0] e;
        start_load(8'h30, 9'd0);
        bus.iLoadValid = 1'b1;
        bus.iLoadData  = 28'hDEAD000;
        @(negedge clk);
        bus.iLoadStart = 1'b0;
        checks++;
        if (st !== 3'b011) begin
            errors++; $display("FAIL zero_done: got %b want 011", st);
        end
        @(negedge clk);
        checks++;
        if (st !== 3'b000) begin
            errors++; $display("FAIL zero_idle1: got %b want 000", st);
        end
        @(negedge clk);
        checks++;
        if (st !== 3'b000) begin
            errors++; $display("FAIL zero_idle2: got %b want 000", st);
        end
        bus.iLoadValid = 1'b0;
        foreach (a[i]) begin
            drive_fetch(a[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== e) begin
                errors++; $display("FAIL zero_fetch[%h]: got %b/%h want 1/%h", a[i], bus.oInstrValid, bus.oInstruction, e);
            end
        end
        bus.iFetchEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_during_load();
        logic [7:0]        a [4] = '{8'h10, 8'h11, 8'h12, 8'h40};
        logic [DATA_W-1:0] e;
        // fetch and load start in the same IDLE cycle: fetch is served
        drive_fetch(8'h00);
        start_load(8'h10, 9'd2);
        @(negedge clk);
        bus.iLoadStart = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== e || st !== 3'b110) begin
            errors++; $display("FAIL same_cycle: got %b/%h/%b want 1/%h/110", bus.oInstrValid, bus.oInstruction, st, e);
        end
        // refused fetch plus an ignored restart attempt
        bus.iAddress = 8'h01;
        start_load(8'h40, 9'd5);
        @(negedge clk);
        bus.iLoadStart = 1'b0;
        checks++;
        if (bus.oInstrValid !== 1'b0 || bus.oInstruction !== NOP) begin
            errors++; $display("FAIL refused_load: got %b/%h want 0/%h", bus.oInstrValid, bus.oInstruction, NOP);
        end
        for (int unsigned i = 0; i < 2; i++) begin
            bus.iLoadValid = 1'b1;
            bus.iLoadData  = 28'h5550000 | DATA_W'(i);
            model_wr(8'h10 + 8'(i), 28'h5550000 | DATA_W'(i));
            @(negedge clk);
        end
        bus.iLoadValid = 1'b0;
        checks++;
        if (st !== 3'b011 || bus.oInstrValid !== 1'b0 || bus.oInstruction !== NOP) begin
            errors++; $display("FAIL refused_done: got %b/%b/%h want 011/0/%h", st, bus.oInstrValid, bus.oInstruction, NOP);
        end
        bus.iFetchEn = 1'b0;
        @(negedge clk);
        checks++;
        if (st !== 3'b000) begin
            errors++; $display("FAIL refused_idle: got %b want 000", st);
        end
        foreach (a[i]) begin
            drive_fetch(a[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== e) begin
                errors++; $display("FAIL ignore_start_fetch[%h]: got %b/%h want 1/%h", a[i], bus.oInstrValid, bus.oInstruction, e);
            end
        end
        bus.iFetchEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        logic [7:0]        a [4] = '{8'h20, 8'h21, 8'h00, 8'hFE};
        logic [DATA_W-1:0] e;
        start_load(8'h20, 9'd5);
        @(negedge clk);
        bus.iLoadStart = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            bus.iLoadValid = 1'b1;
            bus.iLoadData  = 28'h7770000 | DATA_W'(i);
            @(negedge clk);
        end
        bus.iLoadValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if (st !== 3'b000 || bus.oInstrValid !== 1'b0 || bus.oInstruction !== NOP) begin
            errors++; $display("FAIL abort_state: got %b/%b/%h want 000/0/%h", st, bus.oInstrValid, bus.oInstruction, NOP);
        end
        @(negedge clk);
        checks++;
        if (st !== 3'b000) begin
            errors++; $display("FAIL abort_no_done: got %b want 000", st);
        end
        foreach (a[i]) begin
            drive_fetch(a[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== e) begin
                errors++; $display("FAIL abort_fetch[%h]: got %b/%h want 1/%h", a[i], bus.oInstrValid, bus.oInstruction, e);
            end
        end
        bus.iFetchEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_fill();
        logic [7:0]        p = 8'h80;
        logic [7:0]        a [5] = '{8'h80, 8'hFF, 8'h00, 8'h7F, 8'h3C};
        logic [DATA_W-1:0] e;
        start_load(8'h80, 9'd256);
        @(negedge clk);
        bus.iLoadStart = 1'b0;
        for (int unsigned i = 0; i < 256; i++) begin
            if (i == 255) begin
                checks++;
                if (st !== 3'b110) begin
                    errors++; $display("FAIL fill_last_ready: got %b want 110", st);
                end
            end
            bus.iLoadValid = 1'b1;
            bus.iLoadData  = 28'hA5A0000 | DATA_W'(i);
            model_wr(p, 28'hA5A0000 | DATA_W'(i));
            p++;
            @(negedge clk);
        end
        bus.iLoadValid = 1'b0;
        checks++;
        if (st !== 3'b011) begin
            errors++; $display("FAIL fill_done: got %b want 011", st);
        end
        @(negedge clk);
        foreach (a[i]) begin
            drive_fetch(a[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== e) begin
                errors++; $display("FAIL fill_fetch[%h]: got %b/%h want 1/%h", a[i], bus.oInstrValid, bus.oInstruction, e);
            end
        end
        bus.iFetchEn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        bus.iAddress   = '0;
        bus.iFetchEn   = 1'b0;
        bus.iLoadStart = 1'b0;
        bus.iLoadBase  = '0;
        bus.iLoadCount = '0;
        bus.iLoadData  = '0;
        bus.iLoadValid = 1'b0;
        model_clear();
        test_reset();
        test_load_basic();
        test_load_stall_wrap();
        test_load_zero();
        test_fetch_during_load();
        test_reset_mid_load();
        test_full_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
